// File: rtl/nubus_slave_responder.sv
// nubus_slave_responder: NuBus slave that maps card-addressed start cycles onto one local mem_valid/mem_ready access and answers with a single ACK cycle.
// Optional NUBUS_PARITY_EN adds nub_spn/nub_spvn and answers a bad parity cycle with error status.
module nubus_slave_responder #(
  parameter int TIMEOUT = 64
) (
  input  logic        mem_clk,
  input  logic        mem_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [31:0] nub_adn,
`ifdef NUBUS_PARITY_EN
  input  logic        nub_spn,
  input  logic        nub_spvn,
`endif
  output logic        nub_ackn_oe,
  output logic        nub_tmn_oe,
  output logic [1:0]  nub_tmn_o,
  output logic        nub_adn_oe,
  output logic [31:0] nub_adn_o,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_myslot,
  output logic        mem_myexp
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, MEM, ACK} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] lane_q, lane;
  logic rd_q, err_q, blk, hit_slot, hit_exp, par_err;
  logic [31:0] a, mask;
  logic [3:0] slot;
  assign a = ~nub_adn;
  assign slot = ~nub_idn;
  assign hit_slot = a[31:24] == {4'hF, slot};
  assign hit_exp = (a[31:28] == slot) && (slot != 4'h0);
  assign blk = nub_tm0n && (a[1:0] == 2'b01);
  assign mask = {{8{lane_q[3]}}, {8{lane_q[2]}}, {8{lane_q[1]}}, {8{lane_q[0]}}};
`ifdef NUBUS_PARITY_EN
  assign par_err = !nub_spvn && (^{nub_adn, nub_spn});
`else
  assign par_err = 1'b0;
`endif
  // TM0* low selects a single byte lane; otherwise a[1:0] picks word/half/block
  always_comb
    lane = !nub_tm0n ? 4'b0001 << a[1:0] :
           a[1:0] == 2'b00 ? 4'hF :
           a[1:0] == 2'b10 ? 4'h3 :
           a[1:0] == 2'b11 ? 4'hC : 4'h0;
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      nub_ackn_oe <= 1'b0;
      nub_tmn_oe  <= 1'b0;
      nub_tmn_o   <= 2'b11;
      nub_adn_oe  <= 1'b0;
      nub_adn_o   <= '1;
      mem_valid   <= 1'b0;
      mem_wstrb   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_myslot  <= 1'b0;
      mem_myexp   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!nub_startn && nub_ackn && (hit_slot || hit_exp)) begin
          mem_addr   <= {a[31:2], 2'b00};
          lane_q     <= lane;
          mem_wstrb  <= nub_tm1n ? 4'h0 : lane;
          rd_q       <= nub_tm1n;
          err_q      <= blk || par_err;
          mem_myslot <= hit_slot;
          mem_myexp  <= hit_exp;
          state_q    <= DATA;
        end
        DATA: if (err_q || (!rd_q && par_err)) begin
          nub_ackn_oe <= 1'b1;
          nub_tmn_oe  <= 1'b1;
          nub_tmn_o   <= 2'b01;
          nub_adn_oe  <= rd_q;
          nub_adn_o   <= '1;
          state_q     <= ACK;
        end else begin
          if (!rd_q) mem_wdata <= a;
          mem_valid <= 1'b1;
          cnt_q     <= '0;
          state_q   <= MEM;
        end
        MEM: if (mem_ready) begin
          mem_valid   <= 1'b0;
          nub_ackn_oe <= 1'b1;
          nub_tmn_oe  <= 1'b1;
          nub_tmn_o   <= 2'b00;
          nub_adn_oe  <= rd_q;
          nub_adn_o   <= ~(mem_rdata & mask);
          state_q     <= ACK;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          mem_valid   <= 1'b0;
          nub_ackn_oe <= 1'b1;
          nub_tmn_oe  <= 1'b1;
          nub_tmn_o   <= 2'b11;
          nub_adn_oe  <= rd_q;
          nub_adn_o   <= '1;
          state_q     <= ACK;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          nub_ackn_oe <= 1'b0;
          nub_tmn_oe  <= 1'b0;
          nub_tmn_o   <= 2'b11;
          nub_adn_oe  <= 1'b0;
          nub_adn_o   <= '1;
          state_q     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nubus_slave_responder.sv
// tb_nubus_slave_responder: directed checks of decode, memory handshake, ACK status, timeout and reset.
module tb_nubus_slave_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] idn = 4'hF;
  logic startn = 1'b1, ackn = 1'b1, tm1n = 1'b1, tm0n = 1'b1;
  logic [31:0] adn = '1;
  logic ackn_oe, tmn_oe, adn_oe, mem_valid, myslot, myexp;
  logic [1:0] tmn_o;
  logic [31:0] adn_o, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  nubus_slave_responder #(.TIMEOUT(64)) dut (
    .mem_clk(clk), .mem_reset(rst), .nub_idn(idn), .nub_startn(startn), .nub_ackn(ackn),
    .nub_tm1n(tm1n), .nub_tm0n(tm0n), .nub_adn(adn),
`ifdef NUBUS_PARITY_EN
    .nub_spn(1'b1), .nub_spvn(1'b1),
`endif
    .nub_ackn_oe(ackn_oe), .nub_tmn_oe(tmn_oe), .nub_tmn_o(tmn_o), .nub_adn_oe(adn_oe),
    .nub_adn_o(adn_o), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_myslot(myslot),
    .mem_myexp(myexp));

  // start cycle then release the bus; returns at the negedge of the data cycle
  task automatic drive_start(input logic [31:0] addr, input logic rd, input logic t0n);
    @(negedge clk);
    startn = 1'b0; ackn = 1'b1; tm1n = rd; tm0n = t0n; adn = ~addr;
    @(negedge clk);
    startn = 1'b1; tm1n = 1'b1; tm0n = 1'b1; adn = '1;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    vec++; if (ackn_oe !== 1'b0 || tmn_oe !== 1'b0 || adn_oe !== 1'b0) begin errs++; $display("FAIL reset_oe: got %b%b%b want 000", ackn_oe, tmn_oe, adn_oe); end
    vec++; if (tmn_o !== 2'b11 || adn_o !== 32'hFFFFFFFF) begin errs++; $display("FAIL reset_bus: got %b %h want 11 ffffffff", tmn_o, adn_o); end
    vec++; if (mem_valid !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || myslot !== 1'b0 || myexp !== 1'b0) begin errs++; $display("FAIL reset_mem: got v=%b s=%h a=%h d=%h", mem_valid, mem_wstrb, mem_addr, mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_write_word;
    drive_start(32'hF0000000, 1'b0, 1'b1);
    adn = ~32'h87654321;
    @(negedge clk); adn = '1;
    vec++; if (mem_valid !== 1'b1 || mem_wstrb !== 4'hF || mem_addr !== 32'hF0000000) begin errs++; $display("FAIL wr_req: got v=%b s=%h a=%h want 1 f f0000000", mem_valid, mem_wstrb, mem_addr); end
    vec++; if (mem_wdata !== 32'h87654321 || myslot !== 1'b1 || myexp !== 1'b0) begin errs++; $display("FAIL wr_data: got %h slot=%b exp=%b want 87654321 1 0", mem_wdata, myslot, myexp); end
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    vec++; if (ackn_oe !== 1'b1 || tmn_oe !== 1'b1 || tmn_o !== 2'b00 || adn_oe !== 1'b0 || mem_valid !== 1'b0) begin errs++; $display("FAIL wr_ack: got ack=%b tmoe=%b tm=%b adoe=%b v=%b", ackn_oe, tmn_oe, tmn_o, adn_oe, mem_valid); end
    @(negedge clk);
    vec++; if (ackn_oe !== 1'b0 || tmn_oe !== 1'b0) begin errs++; $display("FAIL wr_release: got ack=%b tmoe=%b want 0 0", ackn_oe, tmn_oe); end
  endtask

  task automatic test_read(input logic [31:0] addr, input logic t0n, input logic [31:0] exp_ad, input logic [31:0] exp_addr, input string nm);
    drive_start(addr, 1'b1, t0n);
    @(negedge clk);
    vec++; if (mem_valid !== 1'b1 || mem_wstrb !== 4'h0 || mem_addr !== exp_addr) begin errs++; $display("FAIL %s_req: got v=%b s=%h a=%h want 1 0 %h", nm, mem_valid, mem_wstrb, mem_addr, exp_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h87654321;
    @(negedge clk); mem_ready = 1'b0; mem_rdata = '0;
    vec++; if (ackn_oe !== 1'b1 || tmn_o !== 2'b00 || adn_oe !== 1'b1 || adn_o !== ~exp_ad) begin errs++; $display("FAIL %s_ack: got ack=%b tm=%b adoe=%b ad=%h want 1 00 1 %h", nm, ackn_oe, tmn_o, adn_oe, adn_o, ~exp_ad); end
    @(negedge clk);
    vec++; if (ackn_oe !== 1'b0 || adn_oe !== 1'b0) begin errs++; $display("FAIL %s_release: got ack=%b adoe=%b want 0 0", nm, ackn_oe, adn_oe); end
  endtask

  task automatic test_no_match;
    int seen = 0;
    drive_start(32'hF1000008, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (mem_valid || ackn_oe) seen++; end
    vec++; if (seen !== 0) begin errs++; $display("FAIL no_match: got %0d active cycles want 0", seen); end
    @(negedge clk); startn = 1'b0; ackn = 1'b0; adn = ~32'hF0000000;
    @(negedge clk); startn = 1'b1; ackn = 1'b1; adn = '1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (mem_valid || ackn_oe) seen++; end
    vec++; if (seen !== 0) begin errs++; $display("FAIL attention: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_block;
    int seen = 0;
    drive_start(32'hF0000001, 1'b0, 1'b1);
    @(negedge clk);
    vec++; if (ackn_oe !== 1'b1 || tmn_o !== 2'b01 || mem_valid !== 1'b0) begin errs++; $display("FAIL block_ack: got ack=%b tm=%b v=%b want 1 01 0", ackn_oe, tmn_o, mem_valid); end
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (mem_valid || ackn_oe) seen++; end
    vec++; if (seen !== 0) begin errs++; $display("FAIL block_after: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_expansion;
    idn = ~4'd3;
    drive_start(32'h30000104, 1'b0, 1'b0);
    @(negedge clk);
    vec++; if (mem_valid !== 1'b1 || myexp !== 1'b1 || myslot !== 1'b0 || mem_wstrb !== 4'h1 || mem_addr !== 32'h30000104) begin errs++; $display("FAIL exp_req: got v=%b exp=%b slot=%b s=%h a=%h", mem_valid, myexp, myslot, mem_wstrb, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    idn = 4'hF;
  endtask

  task automatic test_timeout;
    int n = 0;
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    drive_start(32'hF0000000, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (!mem_valid) break; n++; end
    vec++; if (n !== 64) begin errs++; $display("FAIL timeout_len: got %0d cycles want 64", n); end
    vec++; if (ackn_oe !== 1'b1 || tmn_o !== 2'b11) begin errs++; $display("FAIL timeout_ack: got ack=%b tm=%b want 1 11", ackn_oe, tmn_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    drive_start(32'hF0000000, 1'b1, 1'b1);
    @(negedge clk);
    vec++; if (mem_valid !== 1'b1) begin errs++; $display("FAIL mid_pre: got v=%b want 1", mem_valid); end
    rst = 1'b1; #1;
    vec++; if (mem_valid !== 1'b0 || ackn_oe !== 1'b0 || tmn_oe !== 1'b0 || adn_oe !== 1'b0) begin errs++; $display("FAIL mid_reset: got v=%b oe=%b%b%b want 0 000", mem_valid, ackn_oe, tmn_oe, adn_oe); end
    @(negedge clk); rst = 1'b0;
    test_read(32'hF0000000, 1'b1, 32'h87654321, 32'hF0000000, "post_reset");
  endtask

  initial begin
    test_reset;
    test_write_word;
    test_read(32'hF0000000, 1'b1, 32'h87654321, 32'hF0000000, "rd_word");
    test_read(32'hF0000016, 1'b0, 32'h00650000, 32'hF0000014, "rd_byte2");
    test_read(32'hF0000022, 1'b1, 32'h00004321, 32'hF0000020, "rd_half0");
    test_read(32'hF0000023, 1'b1, 32'h87650000, 32'hF0000020, "rd_half1");
    test_no_match;
    test_block;
    test_expansion;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
